// File: rtl/slc3_regfile_cc.sv
// SLC-3 register file with merged condition codes (NZP), branch enable (BEN)
// and per-register dirty tracking. One write port, two combinational read
// ports with optional same-cycle write-through bypass.
module slc3_regfile_cc #(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     NREGS     = 8,
    parameter int unsigned     AW        = $clog2(NREGS),
    parameter bit              BYPASS    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Bus_in,
    input  logic             LD_REG,
    input  logic [AW-1:0]    DR,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic [2:0]       NZP_mask,
    input  logic             Clr_dirty,
    output logic [WIDTH-1:0] SR1_out,
    output logic [WIDTH-1:0] SR2_out,
    output logic [2:0]       CC_out,
    output logic             BEN_out,
    output logic [NREGS-1:0] Dirty
);

    localparam logic [2:0] CC_NEG  = 3'b100;
    localparam logic [2:0] CC_ZERO = 3'b010;
    localparam logic [2:0] CC_POS  = 3'b001;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [2:0]       r_cc;
    logic             r_ben;
    logic [NREGS-1:0] r_dirty;

    logic [2:0]       w_cc_dec;
    logic             w_ben_next;
    logic [NREGS-1:0] w_dirty_next;
    logic [WIDTH-1:0] w_sr1;
    logic [WIDTH-1:0] w_sr2;
    logic             w_hit1;
    logic             w_hit2;

    // Register array: reset to RESET_VAL, otherwise write Bus_in into R[DR].
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (LD_REG) begin
            r_regs[DR] <= Bus_in;
        end
    end

    // Signed decode of the bus value into one-hot {n,z,p}.
    always_comb begin
        w_cc_dec = CC_POS;
        if (Bus_in == '0) begin
            w_cc_dec = CC_ZERO;
        end else if (Bus_in[WIDTH-1]) begin
            w_cc_dec = CC_NEG;
        end
    end

    // Branch enable is evaluated against the CC stored before this edge.
    always_comb begin
        w_ben_next = |(NZP_mask & r_cc);
    end

    // Condition-code and branch-enable state; reset wins over both strobes.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_cc  <= CC_ZERO;
            r_ben <= 1'b0;
        end else begin
            if (LD_CC) begin
                r_cc <= w_cc_dec;
            end
            if (LD_BEN) begin
                r_ben <= w_ben_next;
            end
        end
    end

    // Dirty next state: clear first, then mark the written register.
    always_comb begin
        w_dirty_next = r_dirty;
        if (Clr_dirty) begin
            w_dirty_next = '0;
        end
        if (LD_REG) begin
            w_dirty_next[DR] = 1'b1;
        end
    end

    // Dirty tracking register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= w_dirty_next;
        end
    end

    // Read-port bypass hit detection; only meaningful when BYPASS is enabled.
    always_comb begin
        w_hit1 = BYPASS && LD_REG && (DR == SR1);
        w_hit2 = BYPASS && LD_REG && (DR == SR2);
    end

    // Combinational read ports, each resolving its own bypass independently.
    always_comb begin
        w_sr1 = r_regs[SR1];
        w_sr2 = r_regs[SR2];
        if (w_hit1) begin
            w_sr1 = Bus_in;
        end
        if (w_hit2) begin
            w_sr2 = Bus_in;
        end
    end

    assign SR1_out = w_sr1;
    assign SR2_out = w_sr2;
    assign CC_out  = r_cc;
    assign BEN_out = r_ben;
    assign Dirty   = r_dirty;

endmodule

// File: tb/tb_slc3_regfile_cc.sv
// Bench for slc3_regfile_cc: a 16x8 bypassing instance and a 32x16
// non-bypassing instance share one stimulus stream; a reference model feeds a
// per-instance expectation queue, and a vector table adds hand-derived values.
module tb_slc3_regfile_cc;

    logic        clk;
    logic        rst_n;
    logic [31:0] bus;
    logic        ld_reg;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic        ld_cc;
    logic        ld_ben;
    logic [2:0]  mask;
    logic        clr;

    logic [15:0] a_sr1, a_sr2;
    logic [2:0]  a_cc;
    logic        a_ben;
    logic [7:0]  a_dirty;
    logic [31:0] b_sr1, b_sr2;
    logic [2:0]  b_cc;
    logic        b_ben;
    logic [15:0] b_dirty;

    int checks = 0;
    int errors = 0;

    slc3_regfile_cc #(.WIDTH(16), .NREGS(8), .BYPASS(1'b1)) u_a (
        .Clk(clk), .Reset_n(rst_n), .Bus_in(bus[15:0]), .LD_REG(ld_reg),
        .DR(dr[2:0]), .SR1(sr1[2:0]), .SR2(sr2[2:0]), .LD_CC(ld_cc),
        .LD_BEN(ld_ben), .NZP_mask(mask), .Clr_dirty(clr),
        .SR1_out(a_sr1), .SR2_out(a_sr2), .CC_out(a_cc), .BEN_out(a_ben),
        .Dirty(a_dirty)
    );

    slc3_regfile_cc #(.WIDTH(32), .NREGS(16), .BYPASS(1'b0)) u_b (
        .Clk(clk), .Reset_n(rst_n), .Bus_in(bus), .LD_REG(ld_reg),
        .DR(dr), .SR1(sr1), .SR2(sr2), .LD_CC(ld_cc),
        .LD_BEN(ld_ben), .NZP_mask(mask), .Clr_dirty(clr),
        .SR1_out(b_sr1), .SR2_out(b_sr2), .CC_out(b_cc), .BEN_out(b_ben),
        .Dirty(b_dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sr1;
        logic [31:0] sr2;
        logic [2:0]  cc;
        logic        ben;
        logic [15:0] dirty;
    } exp_t;

    typedef struct {
        logic        rst_n, ld_reg;
        logic [3:0]  dr, sr1, sr2;
        logic [31:0] bus;
        logic        ld_cc, ld_ben;
        logic [2:0]  mask;
        logic        clr, chk;
        logic [15:0] e_sr1, e_sr2;
        logic [2:0]  e_cc;
        logic        e_ben;
        logic [7:0]  e_dirty;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state, index 0 = instance A, 1 = instance B.
    logic [31:0] m_reg [2][16];
    logic [2:0]  m_cc [2];
    logic        m_ben [2];
    logic [15:0] m_dirty [2];
    logic        m_valid = 1'b0;

    function automatic logic [31:0] wmask(input int k);
        return (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [3:0] imask(input int k);
        return (k == 0) ? 4'h7 : 4'hF;
    endfunction

    function automatic logic [2:0] cc_ref(input int k, input logic [31:0] b);
        logic [31:0] v;
        logic        s;
        v = b & wmask(k);
        s = (k == 0) ? v[15] : v[31];
        if (v == 32'd0) return 3'b010;
        if (s) return 3'b100;
        return 3'b001;
    endfunction

    function automatic exp_t model_exp(input int k);
        exp_t        e;
        logic [3:0]  d, s1, s2;
        logic        byp;
        d   = dr & imask(k);
        s1  = sr1 & imask(k);
        s2  = sr2 & imask(k);
        byp = (k == 0);
        e.sr1   = (byp && ld_reg && d == s1) ? (bus & wmask(k)) : m_reg[k][s1];
        e.sr2   = (byp && ld_reg && d == s2) ? (bus & wmask(k)) : m_reg[k][s2];
        e.cc    = m_cc[k];
        e.ben   = m_ben[k];
        e.dirty = m_dirty[k];
        return e;
    endfunction

    task automatic model_update(input int k);
        logic [3:0] d;
        logic       nb;
        d = dr & imask(k);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_reg[k][i] = 32'd0;
            m_cc[k]    = 3'b010;
            m_ben[k]   = 1'b0;
            m_dirty[k] = 16'd0;
        end else begin
            nb = |(mask & m_cc[k]);
            if (ld_reg) m_reg[k][d] = bus & wmask(k);
            if (ld_ben) m_ben[k] = nb;
            if (ld_cc)  m_cc[k] = cc_ref(k, bus);
            if (clr)    m_dirty[k] = 16'd0;
            if (ld_reg) m_dirty[k][d] = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_dut(input int k, input exp_t e);
        if (k == 0) begin
            check("A.sr1", 32'(a_sr1), e.sr1);
            check("A.sr2", 32'(a_sr2), e.sr2);
            check("A.cc", 32'(a_cc), 32'(e.cc));
            check("A.ben", 32'(a_ben), 32'(e.ben));
            check("A.dirty", 32'(a_dirty), 32'(e.dirty));
        end else begin
            check("B.sr1", b_sr1, e.sr1);
            check("B.sr2", b_sr2, e.sr2);
            check("B.cc", 32'(b_cc), 32'(e.cc));
            check("B.ben", 32'(b_ben), 32'(e.ben));
            check("B.dirty", 32'(b_dirty), 32'(e.dirty));
        end
    endtask

    function automatic vec_t mk(
        input logic rs, input logic lr, input logic [3:0] d, input logic [3:0] s1,
        input logic [3:0] s2, input logic [31:0] b, input logic lc, input logic lb,
        input logic [2:0] m, input logic c, input logic ck, input logic [15:0] e1,
        input logic [15:0] e2, input logic [2:0] ec, input logic eb, input logic [7:0] ed);
        vec_t v;
        v.rst_n = rs; v.ld_reg = lr; v.dr = d; v.sr1 = s1; v.sr2 = s2; v.bus = b;
        v.ld_cc = lc; v.ld_ben = lb; v.mask = m; v.clr = c; v.chk = ck;
        v.e_sr1 = e1; v.e_sr2 = e2; v.e_cc = ec; v.e_ben = eb; v.e_dirty = ed;
        return v;
    endfunction

    // One cycle: drive after negedge, queue model expectations, sample, then clock.
    task automatic step(input vec_t v);
        exp_t ea, eb;
        @(negedge clk);
        rst_n = v.rst_n; ld_reg = v.ld_reg; dr = v.dr; sr1 = v.sr1; sr2 = v.sr2;
        bus = v.bus; ld_cc = v.ld_cc; ld_ben = v.ld_ben; mask = v.mask; clr = v.clr;
        if (m_valid) begin
            q_a.push_back(model_exp(0));
            q_b.push_back(model_exp(1));
        end
        #2;
        if (m_valid && q_a.size() > 0 && q_b.size() > 0) begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            compare_dut(0, ea);
            compare_dut(1, eb);
        end
        if (v.chk) begin
            check("T.sr1", 32'(a_sr1), 32'(v.e_sr1));
            check("T.sr2", 32'(a_sr2), 32'(v.e_sr2));
            check("T.cc", 32'(a_cc), 32'(v.e_cc));
            check("T.ben", 32'(a_ben), 32'(v.e_ben));
            check("T.dirty", 32'(a_dirty), 32'(v.e_dirty));
        end
        @(posedge clk);
        model_update(0);
        model_update(1);
        if (!rst_n) m_valid = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        rst_n = 1'b1; bus = '0; ld_reg = 1'b0; dr = '0; sr1 = '0; sr2 = '0;
        ld_cc = 1'b0; ld_ben = 1'b0; mask = '0; clr = 1'b0;

        // Reset with a pending write to R3, then confirm R3 untouched.
        tbl.push_back(mk(0,1,3,3,0,32'h1234,0,0,0,0, 0, 16'h0,16'h0,3'b010,0,8'h00));
        tbl.push_back(mk(1,0,0,3,0,32'h0000,0,0,0,0, 1, 16'h0,16'h0,3'b010,0,8'h00));
        // Bypassed write to R5 on both ports.
        tbl.push_back(mk(1,1,5,5,5,32'hBEEF,0,0,0,0, 1, 16'hBEEF,16'hBEEF,3'b010,0,8'h00));
        tbl.push_back(mk(1,0,0,5,3,32'h0000,0,0,0,0, 1, 16'hBEEF,16'h0000,3'b010,0,8'h20));
        // CC decode: negative, zero, positive.
        tbl.push_back(mk(1,0,0,5,5,32'h8000,1,0,0,0, 1, 16'hBEEF,16'hBEEF,3'b010,0,8'h20));
        tbl.push_back(mk(1,0,0,5,5,32'h0000,1,0,0,0, 1, 16'hBEEF,16'hBEEF,3'b100,0,8'h20));
        tbl.push_back(mk(1,0,0,5,5,32'h7FFF,1,0,0,0, 1, 16'hBEEF,16'hBEEF,3'b010,0,8'h20));
        // LD_CC and LD_BEN together: BEN sees old CC.
        tbl.push_back(mk(1,0,0,5,5,32'h0000,1,1,3'b001,0, 1, 16'hBEEF,16'hBEEF,3'b001,0,8'h20));
        tbl.push_back(mk(1,0,0,5,5,32'h0000,0,1,3'b001,0, 1, 16'hBEEF,16'hBEEF,3'b010,1,8'h20));
        tbl.push_back(mk(1,0,0,5,5,32'h0000,0,1,3'b111,0, 1, 16'hBEEF,16'hBEEF,3'b010,0,8'h20));
        tbl.push_back(mk(1,0,0,5,5,32'h0000,0,1,3'b000,0, 1, 16'hBEEF,16'hBEEF,3'b010,1,8'h20));
        tbl.push_back(mk(1,0,0,5,5,32'h0000,0,0,3'b000,0, 1, 16'hBEEF,16'hBEEF,3'b010,0,8'h20));
        // Fill R0..R7 with i*0x1111.
        tbl.push_back(mk(1,1,0,0,5,32'h0000,0,0,0,0, 1, 16'h0000,16'hBEEF,3'b010,0,8'h20));
        tbl.push_back(mk(1,1,1,1,5,32'h1111,0,0,0,0, 1, 16'h1111,16'hBEEF,3'b010,0,8'h21));
        tbl.push_back(mk(1,1,2,2,5,32'h2222,0,0,0,0, 1, 16'h2222,16'hBEEF,3'b010,0,8'h23));
        tbl.push_back(mk(1,1,3,3,5,32'h3333,0,0,0,0, 1, 16'h3333,16'hBEEF,3'b010,0,8'h27));
        tbl.push_back(mk(1,1,4,4,5,32'h4444,0,0,0,0, 1, 16'h4444,16'hBEEF,3'b010,0,8'h2F));
        tbl.push_back(mk(1,1,5,5,5,32'h5555,0,0,0,0, 1, 16'h5555,16'h5555,3'b010,0,8'h3F));
        tbl.push_back(mk(1,1,6,6,5,32'h6666,0,0,0,0, 1, 16'h6666,16'h5555,3'b010,0,8'h3F));
        tbl.push_back(mk(1,1,7,7,5,32'h7777,0,0,0,0, 1, 16'h7777,16'h5555,3'b010,0,8'h7F));
        // Clear dirty together with a write to R2 -> one-hot dirty.
        tbl.push_back(mk(1,1,2,2,7,32'hABCD,0,0,0,1, 1, 16'hABCD,16'h7777,3'b010,0,8'hFF));
        tbl.push_back(mk(1,0,0,2,1,32'h0000,0,0,0,0, 1, 16'hABCD,16'h1111,3'b010,0,8'h04));
        tbl.push_back(mk(1,0,0,0,6,32'h0000,0,0,0,0, 1, 16'h0000,16'h6666,3'b010,0,8'h04));
        // Reset beats every strobe in the same cycle.
        tbl.push_back(mk(0,1,1,1,1,32'h8000,1,1,3'b111,0, 1, 16'h8000,16'h8000,3'b010,0,8'h04));
        tbl.push_back(mk(1,0,0,1,2,32'h0000,0,0,0,0, 1, 16'h0000,16'h0000,3'b010,0,8'h00));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Wide instance: top register, bit-31 sign, delayed visibility without bypass.
        step(mk(1,1,15,15,15,32'h8000_0000,1,0,0,0, 0, 16'h0,16'h0,3'b0,0,8'h0));
        #2;
        check("B.r15", b_sr1, 32'h8000_0000);
        check("B.cc_neg31", 32'(b_cc), 32'h4);
        check("B.dirty15", 32'(b_dirty), 32'h8000);
        check("A.cc_zero16", 32'(a_cc), 32'h2);
        step(mk(1,0,0,15,7,32'h0000_8000,1,0,0,0, 0, 16'h0,16'h0,3'b0,0,8'h0));
        #2;
        check("B.cc_pos15", 32'(b_cc), 32'h1);
        check("A.cc_neg15", 32'(a_cc), 32'h4);

        // Random regression of both instances against the model.
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            logic [31:0] b;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'h8000_0000 | 32'($urandom);
                2: b = 32'h0000_8000 | (32'($urandom) & 32'h0000_FFFF);
                default: b = 32'($urandom);
            endcase
            v = mk(($urandom_range(0, 49) != 0), 1'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), b, 1'($urandom), 1'($urandom), 3'($urandom),
                   ($urandom_range(0, 7) == 0), 0, 16'h0, 16'h0, 3'b0, 1'b0, 8'h0);
            step(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
